vfd_scan_sequencer: RTL and testbench
=====================================

Name: vfd_scan_sequencer

Overview:
- Sequences one MN15439A grid refresh cycle: blank, latch, unblank, 288-clock Tri-SPI shift window, then grid advance.
- Sits between the 12 MHz system clock and the Tri-SPI output stage. Drives BLK/LAT, the shift enable, the grid number and the bit index the output stage uses to fetch display RAM.
- Owns the host frame-buffer swap handshake, so a swap only takes effect at a frame boundary.

Parameters:
- GRID_COUNT, 52, number of grids scanned per frame.
- SHIFT_BITS, 288, shift-clock cycles per grid (234 pixel bits plus grid bits).
- TICK_DIV, 3846, CLK cycles per grid slot (12 MHz / (60 Hz × 52 grids)).
- BLK_SETUP, 1, CLK cycles BLK is high before LAT rises.
- LAT_WIDTH, 5, CLK cycles LAT is high.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RSTN  in  1  asynchronous active-low reset.
- EN  in  1  scan enable.
- SWAP_REQ  in  1  host requests a buffer swap; level, held until SWAP_ACK.
- BLK  out  1  display blanking.
- LAT  out  1  serial latch.
- SCE  out  1  shift window enable; Tri-SPI clock gate.
- GN  out  6  current grid number, 0..GRID_COUNT-1.
- BIT_CNT  out  9  bit index within the shift window, 0..SHIFT_BITS-1.
- FRAME_START  out  1  one-cycle pulse on entering SHIFT with GN==0.
- BUF_SEL  out  1  active display buffer.
- SWAP_ACK  out  1  one-cycle swap acknowledge.
- OVERRUN  out  1  sticky: grid slot tick arrived while not in WAIT.
- GCP  out  1  gradient control pulse; only driven when VFD_GCP_EN is defined.

Behaviour:
- Reset (RSTN low, asynchronous):
  - outputs: BLK=1, LAT=0, SCE=0, GN=0, BIT_CNT=0, FRAME_START=0, BUF_SEL=0, SWAP_ACK=0, OVERRUN=0, GCP=0;
  - state=IDLE, prescaler=0.
  - Reset mid-shift aborts immediately; the next scan restarts at GN=0.
- Prescaler: counts 0..TICK_DIV-1 continuously while EN=1 and is held at 0 while EN=0. TICK is a one-cycle pulse on wrap.
- States:
  - IDLE: BLK=1. Go to BLANK on TICK when EN=1.
  - BLANK: BLK=1 for BLK_SETUP cycles, then LATCH.
  - LATCH: LAT=1, BLK=1 for LAT_WIDTH cycles, then UNBLANK.
  - UNBLANK: LAT=0, BLK=1 for 1 cycle, then SHIFT.
    - BLK falls in the first SHIFT cycle.
    - FRAME_START pulses in that cycle if GN==0.
  - SHIFT: BLK=0, SCE=1. BIT_CNT increments 0..SHIFT_BITS-1, one per CLK; the cycle with BIT_CNT==SHIFT_BITS-1 is the last SHIFT cycle.
    - Next cycle: SCE=0, BIT_CNT=0, GN advances, go to WAIT.
  - WAIT: BLK=0, holding the latched grid lit. Go to BLANK on TICK if EN=1, or to IDLE if EN=0.
- Latency, TICK to SCE rise: BLK_SETUP+LAT_WIDTH+1 cycles, i.e. 7 at defaults.
- One slot is 7+288=295 cycles, well inside TICK_DIV.
- Grid advance:
  - GN = GN+1; GN==GRID_COUNT-1 wraps to 0.
  - Wrap is the frame end.
- Swap at frame end only:
  - If SWAP_REQ=1 at the wrap cycle: toggle BUF_SEL and pulse SWAP_ACK in that same cycle.
  - A request raised mid-frame waits for the next wrap.
  - SWAP_REQ still high in the cycle after SWAP_ACK is not re-acknowledged until the next frame end.
- EN deassert:
  - During BLANK, LATCH, UNBLANK or SHIFT, the sequence completes normally.
  - In WAIT, go to IDLE, where BLK=1 and GN is retained.
  - On re-enable, scanning resumes at the retained GN.
- OVERRUN: set when TICK occurs in BLANK, LATCH, UNBLANK or SHIFT. That TICK is dropped, not queued. Cleared only by reset.
- Simultaneous: TICK in the same cycle as the SHIFT→WAIT transition counts as overrun and is dropped.

Optional Feature:
- Macro: VFD_GCP_EN.
- Defined: during SHIFT, GCP=1 for exactly one cycle when BIT_CNT ∈ {72,144,192,216,240,256}, giving 6 pulses per grid for 8 grey levels. GCP=0 elsewhere and in all other states.
- Not defined: GCP tied to 0 and no compare logic is generated.

Test Plan:
- Reset release, EN=1, TICK_DIV=400 -> BLK=1 until first TICK. Then BLK high 1 cycle, LAT high 5 cycles, SCE high exactly 288 cycles starting 7 cycles after TICK. FRAME_START pulses with SCE rise, GN=0 during the shift, GN=1 after it.
- Run 52 slots -> GN sequence 0..51 then 0. FRAME_START pulses once per 52 slots.
- SWAP_REQ raised at GN=10, held -> SWAP_ACK single pulse at 51→0 wrap, BUF_SEL 0→1. Hold SWAP_REQ one further cycle -> no second ACK until the following frame end.
- TICK_DIV=200 (< 295) -> OVERRUN sets during the first SHIFT and stays 1. No restart mid-shift; SCE windows remain 288 cycles.
- EN dropped at BIT_CNT=100 -> shift completes to 287, then IDLE with BLK=1 and GN=1 retained. EN re-raised -> next shift uses GN=1.
- With VFD_GCP_EN -> exactly 6 GCP pulses per SHIFT at BIT_CNT 72,144,192,216,240,256. Without it -> GCP constant 0. RSTN low at BIT_CNT=150 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/vfd_scan_sequencer.sv
// MN15439A grid refresh sequencer: blank, latch, unblank, Tri-SPI shift window, grid advance.
// Define VFD_GCP_EN to generate the gradient control pulses on GCP; otherwise GCP is tied low.
module vfd_scan_sequencer #(
  parameter int unsigned GRID_COUNT = 52,
  parameter int unsigned SHIFT_BITS = 288,
  parameter int unsigned TICK_DIV   = 3846,
  parameter int unsigned BLK_SETUP  = 1,
  parameter int unsigned LAT_WIDTH  = 5
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       SWAP_REQ,
  output logic       BLK,
  output logic       LAT,
  output logic       SCE,
  output logic [5:0] GN,
  output logic [8:0] BIT_CNT,
  output logic       FRAME_START,
  output logic       BUF_SEL,
  output logic       SWAP_ACK,
  output logic       OVERRUN,
  output logic       GCP
);

  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PhMax = (BLK_SETUP > LAT_WIDTH) ? BLK_SETUP : LAT_WIDTH;
  localparam int unsigned CW    = (PhMax > 1) ? $clog2(PhMax) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StBlank,
    StLatch,
    StUnblank,
    StShift,
    StWait
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] ph_q, ph_d;
  logic [8:0]    bit_q, bit_d;
  logic [5:0]    gn_q, gn_d;
  logic          buf_q, buf_d;
  logic          ack_q, ack_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          busy;

  // Prescaler only runs while enabled, so re-enable always waits a full slot.
  assign tick = EN && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = '0;
    if (EN && !tick) begin
      presc_d = presc_q + 1'b1;
    end
  end

  assign busy = (state_q == StBlank) || (state_q == StLatch) ||
                (state_q == StUnblank) || (state_q == StShift);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    gn_d    = gn_q;
    buf_d   = buf_q;
    ack_d   = 1'b0;
    // A tick that lands while a slot is still in progress is dropped, not queued.
    ovr_d   = ovr_q | (tick & busy);
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StBlank;
          ph_d    = '0;
        end
      end
      StBlank: begin
        if (ph_q == CW'(BLK_SETUP - 1)) begin
          state_d = StLatch;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StLatch: begin
        if (ph_q == CW'(LAT_WIDTH - 1)) begin
          state_d = StUnblank;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StUnblank: begin
        state_d = StShift;
        bit_d   = '0;
      end
      StShift: begin
        if (bit_q == 9'(SHIFT_BITS - 1)) begin
          state_d = StWait;
          bit_d   = '0;
          if (gn_q == 6'(GRID_COUNT - 1)) begin
            // Frame boundary: the only point where the host buffer swap may land.
            gn_d = '0;
            if (SWAP_REQ) begin
              buf_d = ~buf_q;
              ack_d = 1'b1;
            end
          end else begin
            gn_d = gn_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      StWait: begin
        if (!EN) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d = StBlank;
          ph_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      presc_q <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      gn_q    <= '0;
      buf_q   <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      gn_q    <= gn_d;
      buf_q   <= buf_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign BLK         = !((state_q == StShift) || (state_q == StWait));
  assign LAT         = (state_q == StLatch);
  assign SCE         = (state_q == StShift);
  assign GN          = gn_q;
  assign BIT_CNT     = bit_q;
  assign FRAME_START = (state_q == StShift) && (bit_q == 9'd0) && (gn_q == 6'd0);
  assign BUF_SEL     = buf_q;
  assign SWAP_ACK    = ack_q;
  assign OVERRUN     = ovr_q;

`ifdef VFD_GCP_EN
  // Six pulses split the shift window into 8 grey levels.
  assign GCP = (state_q == StShift) &&
               (bit_q inside {9'd72, 9'd144, 9'd192, 9'd216, 9'd240, 9'd256});
`else
  assign GCP = 1'b0;
`endif

endmodule

// File: tb/tb_vfd_scan_sequencer.sv
// Directed bench for vfd_scan_sequencer: slot timing, grid sequence, swap, overrun, EN, reset.
// Honours VFD_GCP_EN for the expected GCP pulse count.
module tb_vfd_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       en2;
  logic       swap_req;

  logic       blk, lat, sce, frame_start, buf_sel, swap_ack, overrun, gcp;
  logic [5:0] gn;
  logic [8:0] bit_cnt;

  logic       blk2, lat2, sce2, frame_start2, buf_sel2, swap_ack2, overrun2, gcp2;
  logic [5:0] gn2;
  logic [8:0] bit_cnt2;

  int checks = 0;
  int errors = 0;

  int fs_cnt, ack_cnt, ovr_run, ovr_win, ovr_bad;

`ifdef VFD_GCP_EN
  localparam int ExpGcpN   = 6;
  localparam int ExpGcpSum = 72 + 144 + 192 + 216 + 240 + 256;
`else
  localparam int ExpGcpN   = 0;
  localparam int ExpGcpSum = 0;
`endif

  vfd_scan_sequencer #(.TICK_DIV(400)) u_dut (
    .CLK         (clk),
    .RSTN        (rst_n),
    .EN          (en),
    .SWAP_REQ    (swap_req),
    .BLK         (blk),
    .LAT         (lat),
    .SCE         (sce),
    .GN          (gn),
    .BIT_CNT     (bit_cnt),
    .FRAME_START (frame_start),
    .BUF_SEL     (buf_sel),
    .SWAP_ACK    (swap_ack),
    .OVERRUN     (overrun),
    .GCP         (gcp)
  );

  // Slot shorter than blank+latch+shift, so every other tick overruns.
  vfd_scan_sequencer #(.TICK_DIV(200)) u_ovr (
    .CLK         (clk),
    .RSTN        (rst_n),
    .EN          (en2),
    .SWAP_REQ    (1'b0),
    .BLK         (blk2),
    .LAT         (lat2),
    .SCE         (sce2),
    .GN          (gn2),
    .BIT_CNT     (bit_cnt2),
    .FRAME_START (frame_start2),
    .BUF_SEL     (buf_sel2),
    .SWAP_ACK    (swap_ack2),
    .OVERRUN     (overrun2),
    .GCP         (gcp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_cnt  <= 0;
      ack_cnt <= 0;
      ovr_run <= 0;
      ovr_win <= 0;
      ovr_bad <= 0;
    end else begin
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (swap_ack) ack_cnt <= ack_cnt + 1;
      if (sce2) begin
        ovr_run <= ovr_run + 1;
      end else if (ovr_run != 0) begin
        ovr_win <= ovr_win + 1;
        if (ovr_run != 288) ovr_bad <= ovr_bad + 1;
        ovr_run <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(output bit ok);
    bit seen_low;
    ok       = 1'b0;
    seen_low = !sce;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (!sce) begin
        seen_low = 1'b1;
      end else if (seen_low) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!sce) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_blk"}, blk, 1);
    chk({pfx, "_lat"}, lat, 0);
    chk({pfx, "_sce"}, sce, 0);
    chk({pfx, "_gn"}, gn, 0);
    chk({pfx, "_bit_cnt"}, bit_cnt, 0);
    chk({pfx, "_frame_start"}, frame_start, 0);
    chk({pfx, "_buf_sel"}, buf_sel, 0);
    chk({pfx, "_swap_ack"}, swap_ack, 0);
    chk({pfx, "_overrun"}, overrun, 0);
    chk({pfx, "_gcp"}, gcp, 0);
  endtask

  initial begin
    bit   ok;
    int   n, gn_bad, gcp_n, gcp_sum;
    logic exp_buf;

    rst_n    = 1'b0;
    en       = 1'b0;
    en2      = 1'b0;
    swap_req = 1'b0;
    step(3);
    chk_reset_vals("reset");
    chk("ovr_reset", overrun2, 0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    en2   = 1'b1;

    // First slot: tick at prescaler 399, BLANK at 400, LATCH 401..405, UNBLANK 406, SHIFT 407.
    step(399);
    chk("idle_blk", blk, 1);
    chk("idle_sce", sce, 0);
    chk("ovr_pre", overrun2, 0);
    step(1);
    chk("blank_blk", blk, 1);
    chk("blank_lat", lat, 0);
    chk("ovr_set", overrun2, 1);
    step(1);
    chk("latch_first", lat, 1);
    chk("latch_blk", blk, 1);
    step(4);
    chk("latch_last", lat, 1);
    step(1);
    chk("unblank_lat", lat, 0);
    chk("unblank_blk", blk, 1);
    chk("unblank_sce", sce, 0);
    step(1);
    chk("shift_sce", sce, 1);
    chk("shift_blk", blk, 0);
    chk("shift_fs", frame_start, 1);
    chk("shift_bit0", bit_cnt, 0);

    n = 0; gn_bad = 0; gcp_n = 0; gcp_sum = 0;
    while (sce && n < 1000) begin
      n++;
      if (gn !== 6'd0) gn_bad++;
      if (gcp) begin
        gcp_n++;
        gcp_sum += int'(bit_cnt);
      end
      step(1);
    end
    chk("sce_width", n, 288);
    chk("gn_during_shift", gn_bad, 0);
    chk("gcp_count", gcp_n, ExpGcpN);
    chk("gcp_positions", gcp_sum, ExpGcpSum);
    chk("gcp_after", gcp, 0);
    chk("wait_gn", gn, 1);
    chk("wait_blk", blk, 0);
    chk("wait_bit", bit_cnt, 0);

    // Two frames: swap requested at GN=10 and held across the first wrap.
    exp_buf = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int s = 1; s <= 52; s++) begin
        wait_rise(ok);
        chk("sce_rise_timeout", ok, 1);
        chk("gn_seq", gn, s % 52);
        chk("frame_start_seq", frame_start, (s == 52) ? 1 : 0);
        if (f == 0 && s == 10) swap_req = 1'b1;
        if (f == 1 && s == 30) chk("ack_not_repeated", ack_cnt, 1);
        if (s == 51) begin
          chk("ack_before_wrap", ack_cnt, f);
          wait_fall(ok);
          chk("sce_fall_timeout", ok, 1);
          exp_buf = ~exp_buf;
          chk("wrap_gn", gn, 0);
          chk("swap_ack", swap_ack, 1);
          chk("buf_sel", buf_sel, exp_buf);
          step(1);
          chk("swap_ack_single", swap_ack, 0);
          chk("buf_sel_hold", buf_sel, exp_buf);
          chk("fs_per_frame", fs_cnt, f + 1);
          if (f == 1) swap_req = 1'b0;
        end
      end
    end

    // EN dropped mid-shift of grid 0: window completes, then IDLE at GN=1.
    step(100);
    chk("en_drop_bit", bit_cnt, 100);
    en = 1'b0;
    n  = 0;
    while (sce && n < 1000) begin
      n++;
      step(1);
    end
    chk("en_drop_remaining", n, 188);
    chk("en_drop_gn", gn, 1);
    chk("en_drop_wait_blk", blk, 0);
    step(1);
    chk("idle_blk_after_en", blk, 1);
    step(50);
    chk("idle_hold_blk", blk, 1);
    chk("idle_hold_sce", sce, 0);
    chk("idle_hold_gn", gn, 1);

    en = 1'b1;
    step(406);
    chk("reenable_pre", sce, 0);
    step(1);
    chk("reenable_sce", sce, 1);
    chk("reenable_gn", gn, 1);
    chk("reenable_fs", frame_start, 0);

    step(150);
    chk("rst_bit", bit_cnt, 150);
    chk("no_overrun_main", overrun, 0);
    chk("ovr_sticky", overrun2, 1);
    chk("ovr_bad_windows", ovr_bad, 0);
    chk("ovr_windows_seen", (ovr_win > 40) ? 1 : 0, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midshift_reset");
    chk("ovr_cleared", overrun2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
